gate_bist_ctrl: RTL and testbench

Built-in self-test wrapper stage around the combinational gate models (21-input / 10-output gate networks). It sits directly upstream and downstream of the gate model. Upstream, a 21-bit LFSR drives the model's inputs N1..N21 with pseudo-random patterns. Downstream, a 10-bit MISR compacts the model's outputs into a signature and compares it against a golden value after a programmable number of patterns.

---
 rtl/gate_bist_ctrl.sv | 171 +++++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: BIST wrapper around a 21-in / 10-out combinational gate model.
// A Fibonacci LFSR (x^21+x^19+1) drives the gate-model inputs. A MISR (x^10+x^7+1)
// compacts the responses, and the result is compared against a golden signature
// after a programmable number of patterns.
module gate_bist_ctrl #(
  parameter int                IN_W      = 21,
  parameter int                OUT_W     = 10,
  parameter int                CNT_W     = 16,
  parameter logic [IN_W-1:0]   LFSR_SEED = 21'h000001,
  parameter logic [OUT_W-1:0]  MISR_SEED = 10'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  n_patterns,
  input  logic [OUT_W-1:0]  golden,
  output logic [IN_W-1:0]   pat_out,
  input  logic [OUT_W-1:0]  resp_in,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  signature,
  output logic              sig_valid,
  output logic              pass
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // LFSR step, taps at bits 20 and 18 (x^21 + x^19 + 1).
  function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] q);
    lfsr_next = {q[IN_W-2:0], q[IN_W-1] ^ q[IN_W-3]};
  endfunction

  // MISR step, taps at bits 9 and 6 (x^10 + x^7 + 1), then XOR in the response.
  function automatic logic [OUT_W-1:0] misr_next(input logic [OUT_W-1:0] s,
                                                 input logic [OUT_W-1:0] r);
    misr_next = {s[OUT_W-2:0], s[OUT_W-1] ^ s[OUT_W-4]} ^ r;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [IN_W-1:0]   lfsr_q, lfsr_d;
  logic [OUT_W-1:0]  misr_q, misr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sig_valid_q, sig_valid_d;
  logic              pass_q, pass_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort in RUN takes priority over the final-pattern exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_patterns == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rem_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and flag next-values; every output is taken straight from a flop.
  always_comb begin
    rem_d       = rem_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    sig_valid_d = sig_valid_q;
    pass_d      = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d       = n_patterns;
          lfsr_d      = LFSR_SEED;
          misr_d      = MISR_SEED;
          sig_valid_d = 1'b0;
          pass_d      = 1'b0;
        end else begin
          rem_d = rem_q;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Cancelled run: compactor and generator freeze where they are.
          rem_d = rem_q;
        end else begin
          misr_d = misr_next(misr_q, resp_in);
          lfsr_d = lfsr_next(lfsr_q);
          if (rem_q != CNT_ZERO) begin
            rem_d = rem_q - CNT_ONE;
          end else begin
            rem_d = rem_q;
          end
        end
      end
      ST_DONE: begin
        sig_valid_d = 1'b1;
        pass_d      = (misr_q == golden);
      end
      default: begin
        rem_d = rem_q;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_q == ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q       <= CNT_ZERO;
      lfsr_q      <= LFSR_SEED;
      misr_q      <= MISR_SEED;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sig_valid_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sig_valid_q <= sig_valid_d;
      pass_q      <= pass_d;
    end
  end

  assign pat_out   = lfsr_q;
  assign signature = misr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sig_valid = sig_valid_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl with a stand-in 21-in / 10-out gate network.
module tb_gate_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] n_patterns;
  logic [9:0]  golden;
  logic [20:0] pat_out;
  logic [9:0]  resp_in;
  logic        busy;
  logic        done;
  logic [9:0]  signature;
  logic        sig_valid;
  logic        pass;
  logic [1:0]  mode;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gate_bist_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .n_patterns (n_patterns),
    .golden     (golden),
    .pat_out    (pat_out),
    .resp_in    (resp_in),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .sig_valid  (sig_valid),
    .pass       (pass)
  );

  // Stand-in combinational gate network.
  function automatic logic [9:0] gate_model(input logic [20:0] p);
    logic [9:0] g;
    for (int i = 0; i < 10; i++) begin
      g[i] = (p[i] & p[i+11]) ^ (p[2*i] | p[20-i]);
    end
    return g;
  endfunction

  function automatic logic [20:0] ref_lfsr(input logic [20:0] q);
    logic fb;
    fb = q[20] ^ q[18];
    return (q << 1) | {20'd0, fb};
  endfunction

  function automatic logic [9:0] ref_misr(input logic [9:0] s, input logic [9:0] r);
    logic fb;
    fb = s[9] ^ s[6];
    return ((s << 1) | {9'd0, fb}) ^ r;
  endfunction

  // Response source: 0 = tied low, 1 = constant 1, otherwise the gate network.
  always_comb begin
    case (mode)
      2'd0:    resp_in = 10'h000;
      2'd1:    resp_in = 10'h001;
      default: resp_in = gate_model(pat_out);
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    n_patterns = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Long run against the software model; optionally pulses start during RUN.
  task automatic long_run(input logic [9:0] exp_sig, input bit pulse, input string tag);
    int cyc;
    do_start(16'd1000);
    cyc = 0;
    while (!done && cyc < 1100) begin
      start = (pulse && (cyc % 37 == 0)) ? 1'b1 : 1'b0;
      tick();
      cyc++;
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, cyc, 1001);
    check_eq({tag, "_sig"}, signature, exp_sig);
    check_eq({tag, "_pass"}, pass, 1'b1);
    check_eq({tag, "_valid"}, sig_valid, 1'b1);
    tick();
  endtask

  initial begin
    logic [20:0] one;
    logic [20:0] m_l;
    logic [9:0]  m_s;
    bit          seen_done;

    one        = 21'h000001;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    n_patterns = 16'd0;
    golden     = 10'h000;
    mode       = 2'd0;
    tick();
    tick();
    check_eq("rst_pat", pat_out, 21'h000001);
    check_eq("rst_sig", signature, 10'h000);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_valid", sig_valid, 1'b0);
    check_eq("rst_pass", pass, 1'b0);
    rst_n = 1'b1;
    tick();

    // N=20 with a zero response: walking-one patterns, zero signature.
    do_start(16'd20);
    for (int k = 0; k < 20; k++) begin
      check_eq($sformatf("n20_pat%0d", k), pat_out, (k < 19) ? (one << k) : 21'h080001);
      check_eq($sformatf("n20_busy%0d", k), busy, 1'b1);
      check_eq($sformatf("n20_done%0d", k), done, 1'b0);
      tick();
    end
    check_eq("n20_busy_end", busy, 1'b0);
    check_eq("n20_done_early", done, 1'b0);
    tick();
    check_eq("n20_done", done, 1'b1);
    check_eq("n20_sig", signature, 10'h000);
    check_eq("n20_pass", pass, 1'b1);
    check_eq("n20_valid", sig_valid, 1'b1);
    tick();
    check_eq("n20_done_pulse", done, 1'b0);
    check_eq("n20_valid_hold", sig_valid, 1'b1);
    check_eq("n20_pat_hold", pat_out, 21'h100002);

    // N=2 with response 1: signature 0x003, matching and non-matching golden.
    mode   = 2'd1;
    golden = 10'h003;
    do_start(16'd2);
    check_eq("n2_valid_clr", sig_valid, 1'b0);
    check_eq("n2_busy", busy, 1'b1);
    tick();
    tick();
    check_eq("n2_done_early", done, 1'b0);
    tick();
    check_eq("n2_done", done, 1'b1);
    check_eq("n2_sig", signature, 10'h003);
    check_eq("n2_pass", pass, 1'b1);
    tick();
    golden = 10'h002;
    do_start(16'd2);
    tick();
    tick();
    tick();
    check_eq("n2b_done", done, 1'b1);
    check_eq("n2b_sig", signature, 10'h003);
    check_eq("n2b_pass", pass, 1'b0);
    check_eq("n2b_valid", sig_valid, 1'b1);
    tick();

    // N=0: straight to DONE, signature reloaded with the seed.
    mode   = 2'd0;
    golden = 10'h000;
    do_start(16'd0);
    check_eq("n0_busy0", busy, 1'b0);
    check_eq("n0_done_early", done, 1'b0);
    tick();
    check_eq("n0_done", done, 1'b1);
    check_eq("n0_busy1", busy, 1'b0);
    check_eq("n0_sig", signature, 10'h000);
    check_eq("n0_valid", sig_valid, 1'b1);
    tick();
    check_eq("n0_done_pulse", done, 1'b0);

    // Abort at pattern 4 of 10, then a fresh run restarts from the seed.
    do_start(16'd10);
    repeat (4) tick();
    check_eq("ab_pat4", pat_out, 21'h000010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_busy", busy, 1'b0);
    check_eq("ab_pat_hold", pat_out, 21'h000010);
    check_eq("ab_valid", sig_valid, 1'b0);
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      abort = (i == 3) ? 1'b1 : 1'b0;
      if (done) seen_done = 1'b1;
      tick();
    end
    abort = 1'b0;
    check_eq("ab_no_done", seen_done, 1'b0);
    do_start(16'd3);
    check_eq("ab_re_pat0", pat_out, 21'h000001);
    tick();
    check_eq("ab_re_pat1", pat_out, 21'h000002);
    tick();
    check_eq("ab_re_pat2", pat_out, 21'h000004);
    tick();
    tick();
    check_eq("ab_re_done", done, 1'b1);
    tick();

    // Abort coinciding with the final RUN edge wins.
    mode = 2'd1;
    do_start(16'd2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abf_busy", busy, 1'b0);
    check_eq("abf_sig", signature, 10'h001);
    check_eq("abf_valid", sig_valid, 1'b0);
    tick();
    check_eq("abf_no_done", done, 1'b0);

    // Long runs with the gate network against a software model.
    mode = 2'd2;
    m_l  = 21'h000001;
    m_s  = 10'h000;
    for (int i = 0; i < 1000; i++) begin
      m_s = ref_misr(m_s, gate_model(m_l));
      m_l = ref_lfsr(m_l);
    end
    golden = m_s;
    long_run(m_s, 1'b0, "long1");
    long_run(m_s, 1'b1, "long2");

    // Asynchronous reset in the middle of a run.
    mode = 2'd0;
    do_start(16'd10);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_eq("arst_pat", pat_out, 21'h000001);
    check_eq("arst_sig", signature, 10'h000);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_valid", sig_valid, 1'b0);
    check_eq("arst_pass", pass, 1'b0);
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check_eq("arst_no_done", seen_done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
